i2c_codec_slave: RTL and testbench

- I2C target (responder) modelling the audio codec end of the 3-byte control-word write: {device addr+W, reg[6:0]|data[8], data[7:0]}.
- Oversamples SCL/SDA on the system clock, ACKs matching transactions, and commits 9-bit values into a 16-entry register file.
- Used as the bench/loopback partner for the codec config master, and to expose the last configuration to on-board debug logic.

---
 rtl/i2c_codec_slave.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_codec_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_slave.sv
// rtl/i2c_codec_slave.sv - I2C target for 3-byte codec control writes into a 16x9 register file
// Optional read-back of the last committed register: define I2C_CODEC_SLAVE_READ_EN.
module i2c_codec_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         FILT_LEN = 4
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iI2C_SCLK,
  inout  wire          ioI2C_SDAT,
  output logic         oREG_WE,
  output logic [6:0]   oREG_ADDR,
  output logic [8:0]   oREG_DATA,
  output logic [143:0] oREGS,
  output logic         oBUSY,
  output logic [7:0]   oNACK_CNT
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK1, BYTE2, ACK2, EXTRA, IGNORE
`ifdef I2C_CODEC_SLAVE_READ_EN
    , ACK_R, RDATA, RACK
`endif
  } state_t;

  state_t      state, stateNxt;
  logic [1:0]  sync1, sync2, filt, filtD;   // bit 0 = SCL, bit 1 = SDA
  logic [3:0]  filtCnt [2];
  logic [2:0]  bitCnt;
  logic [6:0]  shift;
  logic        ackOn, sdaLow;
  logic [6:0]  regAddr;
  logic        d8;
  logic [7:0]  dLo;
  logic [8:0]  regs [16];
  logic        sRise, sFall, startC, stopC, rxState, ackState, byteDone, addrOk;
  logic [7:0]  rxByte;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filtD      <= 2'b11;
      filtCnt[0] <= '0;
      filtCnt[1] <= '0;
    end else begin
      sync1 <= {ioI2C_SDAT, iI2C_SCLK};
      sync2 <= sync1;
      filtD <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          filtCnt[i] <= '0;
        end else if (filtCnt[i] == 4'(FILT_LEN - 1)) begin
          filt[i]    <= sync2[i];
          filtCnt[i] <= '0;
        end else begin
          filtCnt[i] <= filtCnt[i] + 4'd1;
        end
      end
    end
  end

  // Conditions need SCL stable high on both samples, so a joint SCL/SDA change is plain data.
  assign sRise    = filt[0] & ~filtD[0];
  assign sFall    = ~filt[0] & filtD[0];
  assign startC   = filt[0] & filtD[0] & filtD[1] & ~filt[1];
  assign stopC    = filt[0] & filtD[0] & ~filtD[1] & filt[1];
  assign rxByte   = {shift, filt[1]};
  assign rxState  = (state == ADDR) || (state == BYTE1) || (state == BYTE2) || (state == EXTRA);
  assign byteDone = sRise && rxState && (bitCnt == 3'd7);
`ifdef I2C_CODEC_SLAVE_READ_EN
  logic [6:0] lastReg;
  logic [7:0] txShift;
  logic [1:0] rdIdx;
  logic       mAck;
  logic [8:0] lastVal;
  logic [7:0] rdByte;
  assign ackState = (state == ACK_A) || (state == ACK1) || (state == ACK2) || (state == ACK_R);
  assign addrOk   = (rxByte == {DEV_ADDR, 1'b0}) || (rxByte == {DEV_ADDR, 1'b1});
  assign lastVal  = (lastReg < 7'd16) ? regs[lastReg[3:0]] : 9'd0;
  assign rdByte   = (rdIdx == 2'd0) ? {lastReg, lastVal[8]} :
                    (rdIdx == 2'd1) ? lastVal[7:0] : 8'hFF;
`else
  assign ackState = (state == ACK_A) || (state == ACK1) || (state == ACK2);
  assign addrOk   = (rxByte == {DEV_ADDR, 1'b0});
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (startC) begin
      stateNxt = ADDR;
    end else if (stopC) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        ADDR: if (byteDone) begin
          if (rxByte == {DEV_ADDR, 1'b0}) stateNxt = ACK_A;
`ifdef I2C_CODEC_SLAVE_READ_EN
          else if (rxByte == {DEV_ADDR, 1'b1}) stateNxt = ACK_R;
`endif
          else stateNxt = IGNORE;
        end
        ACK_A: if (sFall && ackOn) stateNxt = BYTE1;
        BYTE1: if (byteDone) stateNxt = ACK1;
        ACK1:  if (sFall && ackOn) stateNxt = BYTE2;
        BYTE2: if (byteDone) stateNxt = ACK2;
        ACK2:  if (sFall && ackOn) stateNxt = EXTRA;
`ifdef I2C_CODEC_SLAVE_READ_EN
        ACK_R: if (sFall && ackOn) stateNxt = RDATA;
        RDATA: if (sFall && bitCnt == 3'd0) stateNxt = RACK;
        RACK:  if (sFall) stateNxt = mAck ? IGNORE : RDATA;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    sdaLow = ackState && ackOn;
`ifdef I2C_CODEC_SLAVE_READ_EN
    if (state == RDATA) sdaLow = ~txShift[7];
`endif
    oBUSY = (state != IDLE);
  end

  assign ioI2C_SDAT = sdaLow ? 1'b0 : 1'bz;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bitCnt    <= '0;
      shift     <= '0;
      ackOn     <= 1'b0;
      regAddr   <= '0;
      d8        <= 1'b0;
      dLo       <= '0;
      oREG_WE   <= 1'b0;
      oREG_ADDR <= '0;
      oREG_DATA <= '0;
      oNACK_CNT <= '0;
      for (int n = 0; n < 16; n++) regs[n] <= '0;
`ifdef I2C_CODEC_SLAVE_READ_EN
      lastReg <= '0;
      txShift <= 8'hFF;
      rdIdx   <= '0;
      mAck    <= 1'b1;
`endif
    end else begin
      oREG_WE <= 1'b0;
      if (startC || stopC) begin
        bitCnt <= '0;
        ackOn  <= 1'b0;
      end else begin
        if (sRise && rxState) shift <= rxByte[6:0];
`ifdef I2C_CODEC_SLAVE_READ_EN
        if (sRise && (rxState || state == RDATA)) bitCnt <= bitCnt + 3'd1;
`else
        if (sRise && rxState) bitCnt <= bitCnt + 3'd1;
`endif
        if (ackState && sFall) ackOn <= ~ackOn;
        if (byteDone && state == ADDR && !addrOk && oNACK_CNT != 8'hFF)
          oNACK_CNT <= oNACK_CNT + 8'd1;
        if (byteDone && state == BYTE1) begin
          regAddr <= rxByte[7:1];
          d8      <= rxByte[0];
        end
        if (byteDone && state == BYTE2) dLo <= rxByte;
        // Commit lands on the cycle after the final ACK slot is released.
        if (state == ACK2 && sFall && ackOn) begin
          oREG_WE   <= 1'b1;
          oREG_ADDR <= regAddr;
          oREG_DATA <= {d8, dLo};
          if (regAddr == 7'd15) begin
            for (int n = 0; n < 16; n++) regs[n] <= '0;
          end else if (regAddr < 7'd16) begin
            regs[regAddr[3:0]] <= {d8, dLo};
          end
`ifdef I2C_CODEC_SLAVE_READ_EN
          lastReg <= regAddr;
`endif
        end
`ifdef I2C_CODEC_SLAVE_READ_EN
        if (state == ACK_R && sFall && ackOn) begin
          txShift <= rdByte;
          rdIdx   <= 2'd1;
        end
        if (state == RDATA && sFall && bitCnt != 3'd0) txShift <= {txShift[6:0], 1'b1};
        if (state == RACK && sRise) mAck <= filt[1];
        if (state == RACK && sFall && !mAck) begin
          txShift <= rdByte;
          if (rdIdx != 2'd2) rdIdx <= rdIdx + 2'd1;
        end
`endif
      end
    end
  end

  always_comb begin
    oREGS = '0;
    for (int n = 0; n < 16; n++) oREGS[9*n +: 9] = regs[n];
  end

endmodule

// File: tb/tb_i2c_codec_slave.sv
// tb/tb_i2c_codec_slave.sv - self-checking bench for i2c_codec_slave (bit-banged master, commit scoreboard)
module tb_i2c_codec_slave;
  localparam int Q = 10;  // quarter SCL period in iCLK cycles (SCL = iCLK/40)

  typedef struct packed { logic [6:0] a; logic [8:0] d; } commit_t;
  typedef struct {
    logic [7:0] a, b1, b2;
    logic [2:0] expAck;
    logic       commit;
  } vec_t;

  logic         iCLK = 1'b0;
  logic         iRST = 1'b1;
  logic         iI2C_SCLK = 1'b1;
  logic         mSdaLow = 1'b0;
  wire          ioI2C_SDAT;
  logic         oREG_WE, oBUSY;
  logic [6:0]   oREG_ADDR;
  logic [8:0]   oREG_DATA;
  logic [143:0] oREGS;
  logic [7:0]   oNACK_CNT;

  int checks = 0;
  int errors = 0;
  commit_t sb[$];
  logic [8:0] mdl [16];
  logic [7:0] mdlNack;
  logic [6:0] lastA;
  logic [8:0] lastD;
  vec_t vecs [9];

  i2c_codec_slave dut (
    .iCLK(iCLK), .iRST(iRST), .iI2C_SCLK(iI2C_SCLK), .ioI2C_SDAT(ioI2C_SDAT),
    .oREG_WE(oREG_WE), .oREG_ADDR(oREG_ADDR), .oREG_DATA(oREG_DATA),
    .oREGS(oREGS), .oBUSY(oBUSY), .oNACK_CNT(oNACK_CNT)
  );

  assign ioI2C_SDAT = mSdaLow ? 1'b0 : 1'bz;
  pullup (ioI2C_SDAT);

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge iCLK) begin
    if (oREG_WE) begin
      commit_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit actual=%0h/%0h expected=none", oREG_ADDR, oREG_DATA);
      end else begin
        e = sb.pop_front();
        if (oREG_ADDR !== e.a || oREG_DATA !== e.d) begin
          errors++;
          $display("FAIL commit actual=%0h/%0h expected=%0h/%0h", oREG_ADDR, oREG_DATA, e.a, e.d);
        end
      end
    end
  end

  function automatic logic [143:0] mdlFlat();
    logic [143:0] f;
    for (int n = 0; n < 16; n++) f[9*n +: 9] = mdl[n];
    return f;
  endfunction

  task automatic expectCommit(input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] r;
    logic [8:0] d;
    r = b1[7:1];
    d = {b1[0], b2};
    sb.push_back({r, d});
    lastA = r;
    lastD = d;
    if (r == 7'd15) for (int n = 0; n < 16; n++) mdl[n] = '0;
    else if (r < 7'd16) mdl[r[3:0]] = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic i2cStart();
    mSdaLow = 1'b0; tick(Q);
    iI2C_SCLK = 1'b1; tick(Q);
    mSdaLow = 1'b1; tick(Q);
    iI2C_SCLK = 1'b0; tick(Q);
  endtask

  task automatic i2cStop();
    mSdaLow = 1'b1; tick(Q);
    iI2C_SCLK = 1'b1; tick(Q);
    mSdaLow = 1'b0; tick(2*Q);
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    mSdaLow = ~b; tick(Q);
    if (glitch) begin
      iI2C_SCLK = 1'b1; tick(2);
      iI2C_SCLK = 1'b0; tick(Q);
    end
    iI2C_SCLK = 1'b1; tick(2*Q);
    iI2C_SCLK = 1'b0; tick(Q);
  endtask

  task automatic sendByte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) sendBit(b[i], glitch);
    mSdaLow = 1'b0; tick(Q);
    iI2C_SCLK = 1'b1; tick(Q);
    ack = (ioI2C_SDAT === 1'b0);
    tick(Q);
    iI2C_SCLK = 1'b0; tick(Q);
  endtask

  task automatic recvByte(input logic masterAck, output logic [7:0] b);
    mSdaLow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(Q);
      iI2C_SCLK = 1'b1; tick(Q);
      b = {b[6:0], (ioI2C_SDAT !== 1'b0)};
      tick(Q);
      iI2C_SCLK = 1'b0;
    end
    tick(Q);
    mSdaLow = masterAck;
    tick(Q);
    iI2C_SCLK = 1'b1; tick(2*Q);
    iI2C_SCLK = 1'b0; tick(Q);
    mSdaLow = 1'b0;
  endtask

  task automatic checkState(input string name);
    check({name, "_regs"}, oREGS, mdlFlat());
    check({name, "_nack"}, 144'(oNACK_CNT), 144'(mdlNack));
    check({name, "_addr_data"}, 144'({oREG_ADDR, oREG_DATA}), 144'({lastA, lastD}));
  endtask

  initial begin
    logic [2:0] acks;
    logic a0, a1, a2, a3;
    logic [7:0] rb;

    vecs[0] = '{8'h34, 8'h12, 8'h01, 3'b111, 1'b1};
    vecs[1] = '{8'h34, 8'h05, 8'hFF, 3'b111, 1'b1};
    vecs[2] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1'b1};
    vecs[3] = '{8'h36, 8'h12, 8'h34, 3'b000, 1'b0};
    vecs[4] = '{8'h34, 8'h1D, 8'h55, 3'b111, 1'b1};
    vecs[5] = '{8'h34, 8'h40, 8'h2A, 3'b111, 1'b1};
    vecs[6] = '{8'h34, 8'h01, 8'h80, 3'b111, 1'b1};
    vecs[7] = '{8'h34, 8'h1F, 8'hAB, 3'b111, 1'b1};
    vecs[8] = '{8'h34, 8'h12, 8'h01, 3'b111, 1'b1};
    for (int n = 0; n < 16; n++) mdl[n] = '0;
    mdlNack = '0;
    lastA = '0;
    lastD = '0;

    tick(4);
    check("reset_outputs", {oREG_WE, oREG_ADDR, oREG_DATA, oBUSY, oNACK_CNT}, '0);
    check("reset_regs", oREGS, '0);
    check("reset_sda", 144'(ioI2C_SDAT === 1'b1), 144'(1));
    iRST = 1'b0;
    tick(20);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].commit) expectCommit(vecs[v].b1, vecs[v].b2);
      else mdlNack = mdlNack + 8'd1;
      i2cStart();
      sendByte(vecs[v].a, 1'b0, a0);
      sendByte(vecs[v].b1, 1'b0, a1);
      sendByte(vecs[v].b2, 1'b0, a2);
      i2cStop();
      acks = {a0, a1, a2};
      check($sformatf("vec%0d_acks", v), 144'(acks), 144'(vecs[v].expAck));
      check($sformatf("vec%0d_busy", v), 144'(oBUSY), 144'(0));
      checkState($sformatf("vec%0d", v));
    end
    check("reg9_bits", 144'(oREGS[89:81]), 144'(9'h001));

    // Fourth byte after a completed write is NACKed but the commit stands.
    expectCommit(8'h1A, 8'h33);
    i2cStart();
    sendByte(8'h34, 1'b0, a0); sendByte(8'h1A, 1'b0, a1);
    sendByte(8'h33, 1'b0, a2); sendByte(8'h77, 1'b0, a3);
    i2cStop();
    check("extra_acks", 144'({a0, a1, a2, a3}), 144'(4'b1110));
    checkState("extra");

    // Repeated START before byte 2 discards the first transaction.
    expectCommit(8'h0A, 8'h06);
    i2cStart();
    sendByte(8'h34, 1'b0, a0); sendByte(8'h08, 1'b0, a1);
    i2cStart();
    sendByte(8'h34, 1'b0, a2); sendByte(8'h0A, 1'b0, a3);
    sendByte(8'h06, 1'b0, a0);
    i2cStop();
    check("rstart_acks", 144'({a1, a2, a3, a0}), 144'(4'b1111));
    checkState("rstart");

    // Short SCL glitches inside byte 1 must not shift extra bits.
    expectCommit(8'h1C, 8'h99);
    i2cStart();
    sendByte(8'h34, 1'b0, a0); sendByte(8'h1C, 1'b1, a1); sendByte(8'h99, 1'b0, a2);
    i2cStop();
    check("glitch_acks", 144'({a0, a1, a2}), 144'(3'b111));
    checkState("glitch");

    // Reset after byte 1 of a write.
    i2cStart();
    sendByte(8'h34, 1'b0, a0); sendByte(8'h12, 1'b0, a1);
    iRST = 1'b1; tick(2); iRST = 1'b0;
    for (int n = 0; n < 16; n++) mdl[n] = '0;
    mdlNack = '0; lastA = '0; lastD = '0;
    tick(1);
    check("midrst_busy", 144'(oBUSY), 144'(0));
    check("midrst_sda", 144'(ioI2C_SDAT === 1'b1), 144'(1));
    sendByte(8'h01, 1'b0, a2);
    i2cStop();
    check("midrst_acks", 144'({a0, a1, a2}), 144'(3'b110));
    checkState("midrst");

`ifdef I2C_CODEC_SLAVE_READ_EN
    expectCommit(8'h12, 8'h01);
    i2cStart();
    sendByte(8'h34, 1'b0, a0); sendByte(8'h12, 1'b0, a1); sendByte(8'h01, 1'b0, a2);
    i2cStop();
    i2cStart();
    sendByte(8'h35, 1'b0, a0);
    check("read_addr_ack", 144'(a0), 144'(1));
    recvByte(1'b1, rb);
    check("read_byte0", 144'(rb), 144'(8'h12));
    recvByte(1'b0, rb);
    check("read_byte1", 144'(rb), 144'(8'h01));
    check("read_nack_sda", 144'(ioI2C_SDAT === 1'b1), 144'(1));
    check("read_nack_busy", 144'(oBUSY), 144'(1));
    i2cStop();
    checkState("read");
`else
    rb = 8'h00;
    mdlNack = mdlNack + 8'd1;
    i2cStart();
    sendByte(8'h35, 1'b0, a0); sendByte(8'h12, 1'b0, a1);
    i2cStop();
    check("read_addr_nack", 144'({a0, a1, rb}), 144'(10'b0));
    checkState("read");
`endif

    tick(10);
    check("scoreboard_empty", 144'(sb.size()), 144'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
